seq_mult_ctrl: RTL and testbench

- Control FSM for the shift-and-add sequential multiplier.
- Sits directly upstream of the multiplier and multiplicand shift registers and the product accumulator. It drives their load, shift and add strobes and consumes the multiplier LSB fed back from the multiplier shift register.
- Runs one N-bit multiplication per start request, with a start/busy/done handshake to the host.

---
 rtl/seq_mult_ctrl_if.sv | 22 ++
 rtl/seq_mult_ctrl.sv | 72 +++++++
 tb/tb_seq_mult_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seq_mult_ctrl_if.sv
// Host/datapath handshake bundle for the shift-and-add multiplier controller.
// The controller takes the slave view; the host and datapath take the master view.
interface seq_mult_ctrl_if;
  logic start;
  logic q0;
  logic load;
  logic acc_clr;
  logic add_en;
  logic shiftr;
  logic busy;
  logic done;

  modport master (
    output start, q0,
    input  load, acc_clr, add_en, shiftr, busy, done
  );

  modport slave (
    input  start, q0,
    output load, acc_clr, add_en, shiftr, busy, done
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Control FSM for an N-iteration shift-and-add multiplier: load, then N add/shift
// pairs, then a one-cycle done pulse. All strobes are decoded from state.
module seq_mult_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           clr,
  seq_mult_ctrl_if.slave bus
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults at the top of always_comb keep every path assigned, so no
  // latch is inferred for state_nxt or cnt_nxt.
  always_comb begin
    state_nxt = S_IDLE;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE:  state_nxt = bus.start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        cnt_nxt   = '0;
        state_nxt = S_ADD;
      end
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        // >= rather than == so a corrupted count still terminates the operation
        if (cnt >= LAST) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt   = cnt + CW'(1);
          state_nxt = S_ADD;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // q0 only reaches add_en, and only through the ADD decode.
  assign bus.load    = (state == S_LOAD);
  assign bus.acc_clr = (state == S_LOAD);
  assign bus.add_en  = (state == S_ADD) & bus.q0;
  assign bus.shiftr  = (state == S_SHIFT);
  assign bus.busy    = (state == S_LOAD) | (state == S_ADD) | (state == S_SHIFT);
  assign bus.done    = (state == S_DONE);

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: N=4 and N=8 instances, the N=8 one optionally
// closed around a behavioural shift-register/accumulator datapath.
module tb_seq_mult_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr4, start4, q0_4;
  logic clr8, start8, q0_8drv, use_dp;
  logic [7:0] a_op, b_op;
  logic [7:0] dp_m, dp_q;
  logic [8:0] dp_a;

  int checks = 0;
  int errors = 0;

  seq_mult_ctrl_if bus4 ();
  seq_mult_ctrl_if bus8 ();

  assign bus4.start = start4;
  assign bus4.q0    = q0_4;
  assign bus8.start = start8;
  assign bus8.q0    = use_dp ? dp_q[0] : q0_8drv;

  seq_mult_ctrl #(.N(4)) dut4 (.clk(clk), .clr(clr4), .bus(bus4.slave));
  seq_mult_ctrl #(.N(8)) dut8 (.clk(clk), .clr(clr8), .bus(bus8.slave));

  // {load, acc_clr, add_en, shiftr, busy, done}
  wire [5:0] obs4 = {bus4.load, bus4.acc_clr, bus4.add_en, bus4.shiftr, bus4.busy, bus4.done};
  wire [5:0] obs8 = {bus8.load, bus8.acc_clr, bus8.add_en, bus8.shiftr, bus8.busy, bus8.done};
  wire [15:0] product = {dp_a[7:0], dp_q};

  // Reference shift-and-add datapath: A holds the high half plus carry, Q the multiplier.
  always_ff @(posedge clk) begin
    if (bus8.load) begin
      dp_m <= a_op;
      dp_q <= b_op;
      dp_a <= '0;
    end else if (bus8.add_en) begin
      dp_a <= dp_a + {1'b0, dp_m};
    end else if (bus8.shiftr) begin
      {dp_a, dp_q} <= {dp_a, dp_q} >> 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected strobes for cycle cyc after the start edge, from the documented latency.
  function automatic logic [5:0] exp_vec(input int n, input int cyc, input logic q);
    if (cyc == 1)              return 6'b110010;
    else if (cyc == 2 * n + 2) return 6'b000001;
    else if (cyc % 2 == 0)     return {2'b00, q, 3'b010};
    else                       return 6'b000110;
  endfunction

  task automatic idle_cycle(input int n, input string tag);
    @(negedge clk);
    check(tag, (n == 4) ? obs4 : obs8, 6'b000000);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the DONE cycle.
  task automatic run_op(input int n, input logic [63:0] qpat, input bit hold, input string tag);
    int adds;
    int shifts;
    int exp_adds;
    logic qv;
    logic [5:0] o;
    adds = 0;
    shifts = 0;
    exp_adds = 0;
    for (int i = 0; i < n; i++) exp_adds += int'(qpat[i]);
    if (n == 4) start4 = 1'b1; else start8 = 1'b1;
    for (int cyc = 1; cyc <= 2 * n + 2; cyc++) begin
      // q0 toggles outside ADD cycles to show it is ignored there
      qv = (cyc % 2 == 0 && cyc <= 2 * n) ? qpat[(cyc - 2) / 2] : cyc[1];
      if (n == 4) q0_4 = qv; else q0_8drv = qv;
      @(negedge clk);
      if (cyc == 1 && !hold) begin
        start4 = 1'b0;
        start8 = 1'b0;
      end
      o = (n == 4) ? obs4 : obs8;
      check($sformatf("%s c%0d", tag, cyc), o, exp_vec(n, cyc, qv));
      adds += int'(o[3]);
      shifts += int'(o[2]);
    end
    check($sformatf("%s add count", tag), adds, exp_adds);
    check($sformatf("%s shift count", tag), shifts, n);
  endtask

  logic [5:0]  basic_exp [11] = '{6'b110010, 6'b001010, 6'b000110, 6'b000010, 6'b000110,
                                  6'b001010, 6'b000110, 6'b001010, 6'b000110, 6'b000001,
                                  6'b000000};
  logic [10:0] basic_q = 11'b11110110111;

  initial begin
    clr4 = 1'b1; clr8 = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    q0_4 = 1'b1; q0_8drv = 1'b1; use_dp = 1'b0;
    a_op = 8'd0; b_op = 8'd0;

    // Reset held across edges, with start and q0 high
    start4 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset n4", obs4, 6'b000000);
    check("reset n8", obs8, 6'b000000);
    start4 = 1'b0; start8 = 1'b0;
    clr4 = 1'b0; clr8 = 1'b0;
    idle_cycle(4, "post reset n4");
    idle_cycle(8, "post reset n8");

    // Basic N=4 op, q0 = 1,0,1,1 in successive ADD states
    start4 = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      q0_4 = basic_q[c - 1];
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
      check($sformatf("basic c%0d", c), obs4, basic_exp[c - 1]);
    end

    // N=8, q0 zero in every ADD: no add_en, 8 shifts, done in cycle 18
    run_op(8, 64'd0, 1'b0, "zero8");
    idle_cycle(8, "zero8 idle");

    // start held high: second op loads in cycle 12 after IDLE in cycle 11
    run_op(4, 64'h5, 1'b1, "held1");
    idle_cycle(4, "held idle c11");
    run_op(4, 64'hA, 1'b0, "held2");
    idle_cycle(4, "held2 idle");

    // Abort in cycle 5 (SHIFT) with asynchronous clr, then a clean restart
    start4 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      q0_4 = 1'b1;
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
    end
    check("abort pre-clr shift", obs4, 6'b000110);
    #2 clr4 = 1'b1;
    #1 check("abort async clear", obs4, 6'b000000);
    @(negedge clk);
    check("abort clr held", obs4, 6'b000000);
    clr4 = 1'b0;
    for (int c = 0; c < 8; c++) idle_cycle(4, $sformatf("abort no done %0d", c));
    run_op(4, 64'hF, 1'b0, "restart");
    idle_cycle(4, "restart idle");

    // Integration with the datapath, N=8; multiplier bits drive q0
    use_dp = 1'b1;
    a_op = 8'd13; b_op = 8'd11;
    run_op(8, 64'd11, 1'b0, "mul 13x11");
    check("product 13x11", product, 16'd143);
    idle_cycle(8, "mul idle 1");
    a_op = 8'd255; b_op = 8'd255;
    run_op(8, 64'd255, 1'b0, "mul 255x255");
    check("product 255x255", product, 16'd65025);
    idle_cycle(8, "mul idle 2");
    a_op = 8'd0; b_op = 8'd200;
    run_op(8, 64'd200, 1'b0, "mul 0x200");
    check("product 0x200", product, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
